truth_table_sweeper: RTL

//   Upstream stimulus/capture stage for small combinational blocks (e.g. a 3-input

---
 rtl/tt_pkg.sv | 21 ++
 rtl/settle_timer.sv | 30 +++
 rtl/truth_table_sweeper.sv | 102 ++++++++++
 3 files changed

// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sweeper: FSM encoding and settle-counter width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tt_pkg;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DRIVE  = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   // Settle counter width; SETTLE values 1..15 fit in it
   localparam int SETTLE_W = 4;

   typedef enum logic [1:0] {
      IDLE   = S_IDLE,
      DRIVE  = S_DRIVE,
      SAMPLE = S_SAMPLE,
      DONE   = S_DONE
   } state_t;

endpackage

// File: rtl/settle_timer.sv
// Down-counter that times how long a vector is held before it is sampled.
// Latency: tc is high in the cycle after the counter reaches zero (load value 0 -> next cycle).
// Backpressure: none; load overrides counting.
module settle_timer
   import tt_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic [SETTLE_W-1:0] load_val,
   input  logic                en,
   output logic                tc
);

   logic [SETTLE_W-1:0] cnt;

   // Load on vector entry, then count down to zero and hold there
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - SETTLE_W'(1);
      end
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all 2^N_IN input vectors to a combinational block and checks its output against a golden table.
// Latency: SETTLE+1 cycles per vector; done rises 1 + 2^N_IN*(SETTLE+1) edges after start is seen.
// Backpressure: start is ignored while busy; results hold in DONE until the next start.
module truth_table_sweeper
   import tt_pkg::*;
#(
   parameter int                    N_IN     = 3,
   parameter logic [(1<<N_IN)-1:0]  EXPECTED = 8'b0011_0001,
   parameter int                    SETTLE   = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic [N_IN-1:0] dut_in,
   input  logic            dut_out,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic [N_IN-1:0] first_fail,
   output logic            fail_valid
);

   localparam logic [N_IN-1:0]     LAST_IDX  = {N_IN{1'b1}};
   // Timer counts down to zero, so a hold of SETTLE cycles needs SETTLE-1 loaded
   localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE - 1);

   state_t state;
   logic   accept;
   logic   mismatch;
   logic   timer_load;
   logic   timer_tc;

   assign accept     = start && ((state == IDLE) || (state == DONE));
   assign mismatch   = (state == SAMPLE) && (dut_out != EXPECTED[dut_in]);
   // Timer restarts whenever a new vector begins its hold
   assign timer_load = accept || ((state == SAMPLE) && (dut_in != LAST_IDX));

   settle_timer u_settle_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (timer_load),
      .load_val (SETTLE_LD),
      .en       (state == DRIVE),
      .tc       (timer_tc)
   );

   // Sweep sequencer with index, comparator results and status flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         dut_in     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         first_fail <= '0;
         fail_valid <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  state      <= DRIVE;
                  dut_in     <= '0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  err_count  <= '0;
                  first_fail <= '0;
                  fail_valid <= 1'b0;
               end
            end
            DRIVE: begin
               if (timer_tc) begin
                  state <= SAMPLE;
               end
            end
            SAMPLE: begin
               // err_count saturates naturally: at most 2^N_IN increments per sweep
               if (mismatch) begin
                  err_count <= err_count + (N_IN+1)'(1);
                  if (!fail_valid) begin
                     first_fail <= dut_in;
                     fail_valid <= 1'b1;
                  end
               end
               if (dut_in == LAST_IDX) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_count == '0) && !mismatch;
               end else begin
                  dut_in <= dut_in + N_IN'(1);
                  state  <= DRIVE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
